// File: rtl/fifo_read_pkg.sv
// fifo_read_pkg: shared packed-sample word layout and consumer FSM states
package fifo_read_pkg;
  localparam int SAMPLE_W = 12;
  localparam int WORD_W = 32;
  localparam int SAMPLE0_LSB = 0;
  localparam int SAMPLE1_LSB = 16;
  localparam logic [WORD_W-1:0] PAD0_MASK = 32'h0000_F000;
  localparam logic [WORD_W-1:0] PAD1_MASK = 32'hF000_0000;
  typedef enum logic [1:0] {IDLE, READ, WAIT_DATA, OUTPUT} state_t;
  function automatic logic pad_error(input logic [WORD_W-1:0] w);
    return |(w & (PAD0_MASK | PAD1_MASK));
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit saturating incrementer with synchronous reset
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk)
    count <= reset ? '0 : (inc && !(&count)) ? count + 1'b1 : count;
endmodule

// File: rtl/fifo_read.sv
// fifo_read: paced Avalon-MM FIFO pop and unpack into two 12-bit samples
module fifo_read
  import fifo_read_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mode,
  input  logic                req,
  input  logic                fifo_empty,
  output logic                fifo_out_read,
  input  logic                fifo_out_waitrequest,
  input  logic [WORD_W-1:0]   fifo_out_readdata,
  output logic [SAMPLE_W-1:0] sample0,
  output logic [SAMPLE_W-1:0] sample1,
  output logic                sample_valid,
  output logic                busy,
  output logic [CNT_W-1:0]    underrun_count,
  output logic [CNT_W-1:0]    missed_count,
  output logic                format_error
);
  localparam logic [2:0] LAT = 3'(READ_LATENCY);
  state_t     state;
  logic       req_q, pending, rise, service;
  logic [2:0] lat_cnt;
  assign rise = req && !req_q && !mode;
  assign service = state == IDLE && pending && !mode;
  always_ff @(posedge clk) begin
    req_q <= reset ? 1'b0 : req;
    pending <= reset || mode ? 1'b0 : rise || (pending && !service);
  end
  sat_counter #(.W(CNT_W)) u_underrun (
    .clk(clk), .reset(reset), .inc(service && fifo_empty), .count(underrun_count)
  );
  sat_counter #(.W(CNT_W)) u_missed (
    .clk(clk), .reset(reset), .inc(rise && pending && !service), .count(missed_count)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      fifo_out_read <= 1'b0;
      sample0 <= '0;
      sample1 <= '0;
      sample_valid <= 1'b0;
      busy <= 1'b0;
      format_error <= 1'b0;
      lat_cnt <= '0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: if (service && !fifo_empty) begin
          state <= READ;
          fifo_out_read <= 1'b1;
          busy <= 1'b1;
        end
        READ: if (!fifo_out_waitrequest) begin
          state <= WAIT_DATA;
          fifo_out_read <= 1'b0;
          lat_cnt <= 3'd1;
        end
        WAIT_DATA: if (lat_cnt == LAT) begin
          state <= OUTPUT;
          sample0 <= fifo_out_readdata[SAMPLE0_LSB +: SAMPLE_W];
          sample1 <= fifo_out_readdata[SAMPLE1_LSB +: SAMPLE_W];
          sample_valid <= 1'b1;
          format_error <= format_error || pad_error(fifo_out_readdata);
        end else lat_cnt <= lat_cnt + 3'd1;
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_read.sv
// tb_fifo_read: directed self-checking bench for fifo_read
module tb_fifo_read;
  logic        clk = 0, reset, mode, req, fifo_empty, fifo_out_read, fifo_out_waitrequest;
  logic [31:0] fifo_out_readdata, word;
  logic [11:0] sample0, sample1;
  logic        sample_valid, busy, format_error;
  logic [3:0]  underrun_count, missed_count;
  int          checks = 0, errors = 0, nvalid = 0, nread = 0;
  fifo_read #(.READ_LATENCY(1), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .mode(mode), .req(req), .fifo_empty(fifo_empty),
    .fifo_out_read(fifo_out_read), .fifo_out_waitrequest(fifo_out_waitrequest),
    .fifo_out_readdata(fifo_out_readdata), .sample0(sample0), .sample1(sample1),
    .sample_valid(sample_valid), .busy(busy), .underrun_count(underrun_count),
    .missed_count(missed_count), .format_error(format_error)
  );
  always #5 clk = ~clk;
  // FIFO slave model: data valid one cycle after an accepted read, garbage otherwise
  always @(posedge clk)
    fifo_out_readdata <= (fifo_out_read && !fifo_out_waitrequest) ? word : 32'hFFFF_FFFF;
  always @(negedge clk) begin
    if (sample_valid) nvalid <= nvalid + 1;
    if (fifo_out_read) nread <= nread + 1;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_req;
    req = 1;
    tick;
    req = 0;
    tick;
    tick;
  endtask
  task automatic wait_valid(input string name);
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick;
      ok = sample_valid;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: sample_valid never seen within 40 cycles", name);
    end
  endtask
  task automatic test_reset;
    reset = 1; mode = 0; req = 0; fifo_empty = 0; fifo_out_waitrequest = 0; word = 0;
    repeat (3) tick;
    checks++;
    if ({fifo_out_read, sample0, sample1, sample_valid, busy, underrun_count, missed_count, format_error} !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h want 0", {fifo_out_read, sample0, sample1, sample_valid, busy, underrun_count, missed_count, format_error});
    end
    reset = 0;
    tick;
  endtask
  task automatic test_reset_mid_read;
    int v0, r0;
    word = 32'h0ABC_0123;
    fifo_out_waitrequest = 1;
    req = 1;
    tick;
    req = 0;
    tick;
    tick;
    checks++;
    if (fifo_out_read !== 1 || busy !== 1) begin
      errors++;
      $display("FAIL mid_read_setup: read %b busy %b want 1 1", fifo_out_read, busy);
    end
    reset = 1;
    tick;
    reset = 0;
    checks++;
    if (fifo_out_read !== 0 || busy !== 0) begin
      errors++;
      $display("FAIL mid_read_reset: read %b busy %b want 0 0", fifo_out_read, busy);
    end
    fifo_out_waitrequest = 0;
    tick;
    v0 = nvalid; r0 = nread;
    repeat (10) tick;
    checks++;
    if (nvalid != v0 || nread != r0 || sample0 !== 0 || sample1 !== 0) begin
      errors++;
      $display("FAIL mid_read_after: valids %0d reads %0d s0 %h s1 %h want 0 0 0 0", nvalid - v0, nread - r0, sample0, sample1);
    end
  endtask
  task automatic test_basic;
    word = 32'h0ABC_0123;
    fifo_out_waitrequest = 0;
    req = 1;
    for (int c = 2; c <= 4; c++) begin
      tick;
      req = 0;
      checks++;
      if (sample_valid !== 0) begin
        errors++;
        $display("FAIL basic_early_valid: cycle %0d got 1 want 0", c);
      end
      if (c == 3) begin
        checks++;
        if (fifo_out_read !== 1 || busy !== 1) begin
          errors++;
          $display("FAIL basic_read: read %b busy %b want 1 1", fifo_out_read, busy);
        end
      end
    end
    tick;
    checks++;
    if (sample_valid !== 1 || sample0 !== 12'h123 || sample1 !== 12'hABC || format_error !== 0) begin
      errors++;
      $display("FAIL basic_output: v %b s0 %h s1 %h fe %b want 1 123 abc 0", sample_valid, sample0, sample1, format_error);
    end
    tick;
    checks++;
    if (sample_valid !== 0 || busy !== 0) begin
      errors++;
      $display("FAIL basic_pulse: v %b busy %b want 0 0", sample_valid, busy);
    end
  endtask
  task automatic test_underrun;
    int v0, r0;
    fifo_empty = 1;
    v0 = nvalid; r0 = nread;
    repeat (3) begin
      req = 1;
      tick;
      req = 0;
      repeat (9) tick;
    end
    checks++;
    if (underrun_count !== 4'd3) begin
      errors++;
      $display("FAIL underrun_count: got %0d want 3", underrun_count);
    end
    checks++;
    if (nvalid != v0 || nread != r0 || sample0 !== 12'h123 || sample1 !== 12'hABC) begin
      errors++;
      $display("FAIL underrun_quiet: valids %0d reads %0d s0 %h s1 %h want 0 0 123 abc", nvalid - v0, nread - r0, sample0, sample1);
    end
    fifo_empty = 0;
  endtask
  task automatic test_wait_missed;
    int v0, r0, rc = 0;
    word = 32'h0555_0AAA;
    v0 = nvalid; r0 = nread;
    fifo_out_waitrequest = 1;
    for (int i = 0; i < 30; i++) begin
      req = (i == 0 || i == 2 || i == 4);
      tick;
      if (fifo_out_read) rc++;
      fifo_out_waitrequest = rc < 5;
    end
    req = 0;
    checks++;
    if (nread - r0 != 6) begin
      errors++;
      $display("FAIL wait_read_cycles: got %0d want 6", nread - r0);
    end
    checks++;
    if (missed_count !== 4'd1) begin
      errors++;
      $display("FAIL missed_count: got %0d want 1", missed_count);
    end
    checks++;
    if (nvalid - v0 != 2) begin
      errors++;
      $display("FAIL wait_valids: got %0d want 2", nvalid - v0);
    end
    checks++;
    if (sample0 !== 12'hAAA || sample1 !== 12'h555 || underrun_count !== 4'd3) begin
      errors++;
      $display("FAIL wait_samples: s0 %h s1 %h ur %0d want aaa 555 3", sample0, sample1, underrun_count);
    end
  endtask
  task automatic test_format;
    checks++;
    if (format_error !== 0) begin
      errors++;
      $display("FAIL format_pre: got %b want 0", format_error);
    end
    word = 32'hF000_0001;
    req = 1;
    tick;
    req = 0;
    wait_valid("format_bad_valid");
    checks++;
    if (sample0 !== 12'h001 || sample1 !== 12'h000 || format_error !== 1) begin
      errors++;
      $display("FAIL format_bad: s0 %h s1 %h fe %b want 001 000 1", sample0, sample1, format_error);
    end
    tick;
    word = 32'h0001_0002;
    req = 1;
    tick;
    req = 0;
    wait_valid("format_good_valid");
    checks++;
    if (sample0 !== 12'h002 || sample1 !== 12'h001 || format_error !== 1) begin
      errors++;
      $display("FAIL format_sticky: s0 %h s1 %h fe %b want 002 001 1", sample0, sample1, format_error);
    end
    tick;
  endtask
  task automatic test_mode_sat;
    int v0, r0;
    word = 32'h0123_0456;
    req = 1;
    tick;
    req = 0;
    tick;
    tick;
    mode = 1;
    tick;
    checks++;
    if (sample_valid !== 1 || sample0 !== 12'h456 || sample1 !== 12'h123) begin
      errors++;
      $display("FAIL mode_inflight: v %b s0 %h s1 %h want 1 456 123", sample_valid, sample0, sample1);
    end
    tick;
    v0 = nvalid; r0 = nread;
    repeat (3) begin
      pulse_req;
      tick;
    end
    mode = 0;
    repeat (4) tick;
    checks++;
    if (nvalid != v0 || nread != r0 || busy !== 0) begin
      errors++;
      $display("FAIL mode_idle: valids %0d reads %0d busy %b want 0 0 0", nvalid - v0, nread - r0, busy);
    end
    word = 32'h0321_0654;
    req = 1;
    tick;
    req = 0;
    wait_valid("mode_resume_valid");
    checks++;
    if (sample0 !== 12'h654 || sample1 !== 12'h321) begin
      errors++;
      $display("FAIL mode_resume: s0 %h s1 %h want 654 321", sample0, sample1);
    end
    tick;
    fifo_empty = 1;
    repeat (12) pulse_req;
    checks++;
    if (underrun_count !== 4'hF) begin
      errors++;
      $display("FAIL underrun_full: got %h want f", underrun_count);
    end
    pulse_req;
    checks++;
    if (underrun_count !== 4'hF || missed_count !== 4'd1) begin
      errors++;
      $display("FAIL underrun_sat: ur %h missed %h want f 1", underrun_count, missed_count);
    end
  endtask
  initial begin
    test_reset;
    test_reset_mid_read;
    test_basic;
    test_underrun;
    test_wait_missed;
    test_format;
    test_mode_sat;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
